mem_bus_arbiter: RTL and testbench

//  Shares one external 16-bit memory bus between the core's instruction-fetch port and its data (mem/wb) port.

---
 rtl/mem_bus_arbiter_if.sv | 38 +++
 rtl/mem_bus_arbiter.sv | 146 ++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_if.sv
// Core-side request/response signals and external memory bus of mem_bus_arbiter.
// The master modport is the arbiter's view; slave is the core plus memory.
interface mem_bus_arbiter_if #(
  parameter int RW     = 16,
  parameter int I_SIZE = 32
);
  logic              i_f_req_active;
  logic [RW-1:0]     i_f_req_addr;
  logic [I_SIZE-1:0] o_f_data;
  logic              o_f_data_valid;
  logic              i_d_req;
  logic              i_d_we;
  logic [RW-1:0]     i_d_addr;
  logic [RW-1:0]     i_d_wdata;
  logic [RW-1:0]     o_d_rdata;
  logic              o_d_ack;
  logic              o_bus_req;
  logic              o_bus_we;
  logic [RW+1:0]     o_bus_addr;
  logic [RW-1:0]     o_bus_wdata;
  logic [RW-1:0]     i_bus_rdata;
  logic              i_bus_ack;
  logic              o_bus_err;

  modport master (
    input  i_f_req_active, i_f_req_addr, i_d_req, i_d_we, i_d_addr, i_d_wdata,
    input  i_bus_rdata, i_bus_ack,
    output o_f_data, o_f_data_valid, o_d_rdata, o_d_ack,
    output o_bus_req, o_bus_we, o_bus_addr, o_bus_wdata, o_bus_err
  );

  modport slave (
    output i_f_req_active, i_f_req_addr, i_d_req, i_d_we, i_d_addr, i_d_wdata,
    output i_bus_rdata, i_bus_ack,
    input  o_f_data, o_f_data_valid, o_d_rdata, o_d_ack,
    input  o_bus_req, o_bus_we, o_bus_addr, o_bus_wdata, o_bus_err
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares one 16-bit memory bus between instruction fetch (two beats) and data access (one beat)
// with a per-beat watchdog. Define ARB_ROUND_ROBIN_EN for round-robin ties; default is data-first.
module mem_bus_arbiter #(
  parameter int RW      = 16,
  parameter int I_SIZE  = 32,
  parameter int TIMEOUT = 255
) (
  input logic               i_clk,
  input logic               i_rst,
  mem_bus_arbiter_if.master bus
);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, I_LO, I_HI, D_ACC} state_t;

  state_t        state_q, state_d;
  logic          gap_q, dropped_q, d_we_q;
  logic [CW-1:0] wd_cnt_q;
  logic [RW-1:0] f_addr_q, d_addr_q, d_wdata_q, beat_rdata;
  logic          f_req_eff, d_req_eff, grant_f, grant_d;
  logic          beat_active, wd_expire, beat_done, req_live;

  // A requester whose response pulses this cycle is still asserted; it must not be regranted.
  assign f_req_eff = bus.i_f_req_active && !bus.o_f_data_valid;
  assign d_req_eff = bus.i_d_req && !bus.o_d_ack;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_fetch_q;

  assign grant_f = f_req_eff && (!d_req_eff || !last_fetch_q);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst)
      last_fetch_q <= 1'b1;
    else if (state_q == IDLE && (grant_f || grant_d))
      last_fetch_q <= grant_f;
  end
`else
  assign grant_f = f_req_eff && !d_req_eff;
`endif
  assign grant_d = d_req_eff && !grant_f;

  // gap_q holds the bus idle for one cycle between the low and high fetch beats.
  assign beat_active = (state_q != IDLE) && !gap_q;
  assign wd_expire   = (TIMEOUT != 0) && beat_active && !bus.i_bus_ack &&
                       (wd_cnt_q == CW'(TIMEOUT - 1));
  assign beat_done   = beat_active && (bus.i_bus_ack || wd_expire);
  assign beat_rdata  = bus.i_bus_ack ? bus.i_bus_rdata : {RW{1'b1}};
  assign req_live    = (state_q == D_ACC) ? bus.i_d_req : bus.i_f_req_active;
  assign bus.o_bus_req = beat_active;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d         = state_q;
    bus.o_bus_addr  = '0;
    bus.o_bus_we    = 1'b0;
    bus.o_bus_wdata = '0;
    case (state_q)
      IDLE: begin
        if (grant_d)
          state_d = D_ACC;
        else if (grant_f)
          state_d = I_LO;
      end
      I_LO: begin
        bus.o_bus_addr = {1'b0, f_addr_q, 1'b0};
        if (beat_done)
          state_d = I_HI;
      end
      I_HI: begin
        bus.o_bus_addr = {1'b0, f_addr_q, 1'b1};
        if (beat_done)
          state_d = IDLE;
      end
      D_ACC: begin
        bus.o_bus_addr  = {1'b1, 1'b0, d_addr_q};
        bus.o_bus_we    = d_we_q;
        bus.o_bus_wdata = d_we_q ? d_wdata_q : '0;
        if (beat_done)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (!beat_active) begin
      bus.o_bus_addr  = '0;
      bus.o_bus_we    = 1'b0;
      bus.o_bus_wdata = '0;
    end
  end

  // Request fields are frozen at grant; a requester that lets go mid-transaction loses its pulse.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      gap_q              <= 1'b0;
      dropped_q          <= 1'b0;
      wd_cnt_q           <= '0;
      f_addr_q           <= '0;
      d_addr_q           <= '0;
      d_wdata_q          <= '0;
      d_we_q             <= 1'b0;
      bus.o_f_data       <= '0;
      bus.o_f_data_valid <= 1'b0;
      bus.o_d_rdata      <= '0;
      bus.o_d_ack        <= 1'b0;
      bus.o_bus_err      <= 1'b0;
    end else begin
      gap_q              <= (state_q == I_LO) && beat_done;
      wd_cnt_q           <= (beat_active && !bus.i_bus_ack) ? wd_cnt_q + CW'(1) : '0;
      bus.o_bus_err      <= wd_expire;
      bus.o_f_data_valid <= 1'b0;
      bus.o_d_ack        <= 1'b0;
      if (state_q == IDLE) begin
        dropped_q <= 1'b0;
        if (grant_f)
          f_addr_q <= bus.i_f_req_addr;
        if (grant_d) begin
          d_addr_q  <= bus.i_d_addr;
          d_wdata_q <= bus.i_d_wdata;
          d_we_q    <= bus.i_d_we;
        end
      end else if (!req_live) begin
        dropped_q <= 1'b1;
      end
      if (beat_done) begin
        case (state_q)
          I_LO: bus.o_f_data[RW-1:0] <= beat_rdata;
          I_HI: begin
            bus.o_f_data[I_SIZE-1:RW] <= beat_rdata;
            bus.o_f_data_valid        <= req_live && !dropped_q;
          end
          D_ACC: begin
            bus.o_d_rdata <= d_we_q ? '0 : beat_rdata;
            bus.o_d_ack   <= req_live && !dropped_q;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: stimulus pushes expected beats/responses with their cycle,
// a negedge monitor pops and compares them; a behavioural memory answers the bus.
module tb_mem_bus_arbiter;
  localparam int RW = 16;

  typedef struct {
    int          cyc;
    logic [17:0] addr;
    logic        we;
    logic [15:0] wdata;
    int          len;
  } beat_t;

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } rsp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   mem_mute = 1'b0;

  logic [15:0] mem [logic [17:0]];
  beat_t       beat_q[$];
  rsp_t        f_q[$];
  rsp_t        d_q[$];
  int          err_q[$];

  mem_bus_arbiter_if #(.RW(RW), .I_SIZE(2*RW)) bus ();

  mem_bus_arbiter #(.RW(RW), .I_SIZE(2*RW), .TIMEOUT(4)) dut (
    .i_clk (clk),
    .i_rst (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic report_unexpected(input string name);
    n_checks++;
    n_fail++;
    $display("[TB] FAIL %s: event seen with nothing expected (cycle %0d)", name, cyc);
  endtask

  task automatic push_beat(input int c, input logic [17:0] a, input logic w, input logic [15:0] wd, input int l);
    beat_q.push_back('{cyc: c, addr: a, we: w, wdata: wd, len: l});
  endtask

  task automatic push_f(input int c, input logic [31:0] d);
    f_q.push_back('{cyc: c, data: d});
  endtask

  task automatic push_d(input int c, input logic [15:0] d);
    d_q.push_back('{cyc: c, data: {16'h0, d}});
  endtask

  task automatic applyStimulus(input bit do_f, input logic [15:0] f_addr, input bit do_d,
                               input logic d_we, input logic [15:0] d_addr, input logic [15:0] d_wdata);
    if (do_f) begin
      bus.i_f_req_active = 1'b1;
      bus.i_f_req_addr   = f_addr;
    end
    if (do_d) begin
      bus.i_d_req   = 1'b1;
      bus.i_d_we    = d_we;
      bus.i_d_addr  = d_addr;
      bus.i_d_wdata = d_wdata;
    end
  endtask

  // Holds each request until its response pulse, releasing it just after that cycle ends.
  task automatic wait_done(input bit want_f, input bit want_d, input int budget);
    bit f_seen = !want_f;
    bit d_seen = !want_d;
    int n = 0;
    while (!(f_seen && d_seen) && n < budget) begin
      @(negedge clk);
      if (bus.o_f_data_valid) f_seen = 1'b1;
      if (bus.o_d_ack) d_seen = 1'b1;
      @(posedge clk);
      #1;
      if (f_seen) bus.i_f_req_active = 1'b0;
      if (d_seen) bus.i_d_req = 1'b0;
      n++;
    end
    if (!(f_seen && d_seen)) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL wait_done: no response within %0d cycles (fetch seen %0d, data seen %0d)",
               budget, f_seen, d_seen);
      bus.i_f_req_active = 1'b0;
      bus.i_d_req        = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Zero-wait memory: acks every active beat in its first cycle unless muted.
  initial begin
    bus.i_bus_ack   = 1'b0;
    bus.i_bus_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus.o_bus_req && !mem_mute) begin
        bus.i_bus_ack = 1'b1;
        if (bus.o_bus_we) begin
          mem[bus.o_bus_addr] = bus.o_bus_wdata;
          bus.i_bus_rdata     = '0;
        end else begin
          bus.i_bus_rdata = mem.exists(bus.o_bus_addr) ? mem[bus.o_bus_addr] : 16'h0000;
        end
      end else begin
        bus.i_bus_ack   = 1'b0;
        bus.i_bus_rdata = '0;
      end
    end
  end

  initial begin
    bit    req_prev = 1'b0;
    bit    have_cur = 1'b0;
    int    beat_len = 0;
    beat_t cur;
    rsp_t  r;
    int    e;
    forever begin
      @(negedge clk);
      if (bus.o_bus_req && !req_prev) begin
        if (beat_q.size() == 0) begin
          report_unexpected("bus_beat");
          have_cur = 1'b0;
        end else begin
          cur = beat_q.pop_front();
          have_cur = 1'b1;
          checkOutput("beat_cycle", 32'(cyc), 32'(cur.cyc));
          checkOutput("beat_addr", 32'(bus.o_bus_addr), 32'(cur.addr));
          checkOutput("beat_we", 32'(bus.o_bus_we), 32'(cur.we));
          checkOutput("beat_wdata", 32'(bus.o_bus_wdata), 32'(cur.wdata));
        end
        beat_len = 1;
      end else if (bus.o_bus_req) begin
        beat_len++;
      end else if (req_prev && have_cur) begin
        checkOutput("beat_length", 32'(beat_len), 32'(cur.len));
        have_cur = 1'b0;
      end
      req_prev = bus.o_bus_req;
      if (bus.o_f_data_valid) begin
        if (f_q.size() == 0) report_unexpected("f_data_valid");
        else begin
          r = f_q.pop_front();
          checkOutput("f_valid_cycle", 32'(cyc), 32'(r.cyc));
          checkOutput("f_data", bus.o_f_data, r.data);
        end
      end
      if (bus.o_d_ack) begin
        if (d_q.size() == 0) report_unexpected("d_ack");
        else begin
          r = d_q.pop_front();
          checkOutput("d_ack_cycle", 32'(cyc), 32'(r.cyc));
          checkOutput("d_rdata", 32'(bus.o_d_rdata), r.data);
        end
      end
      if (bus.o_bus_err) begin
        if (err_q.size() == 0) report_unexpected("bus_err");
        else begin
          e = err_q.pop_front();
          checkOutput("bus_err_cycle", 32'(cyc), 32'(e));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL sim_time_limit: got no end of test, expected end before 100000");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    int n;
    rst_n              = 1'b0;
    bus.i_f_req_active = 1'b0;
    bus.i_f_req_addr   = '0;
    bus.i_d_req        = 1'b0;
    bus.i_d_we         = 1'b0;
    bus.i_d_addr       = '0;
    bus.i_d_wdata      = '0;
    mem[18'h00024] = 16'h1111;
    mem[18'h00025] = 16'h2222;
    mem[18'h00026] = 16'h3333;
    mem[18'h00027] = 16'h4444;
    mem[18'h00200] = 16'hAAAA;
    mem[18'h00201] = 16'h5555;
    mem[18'h20041] = 16'h1234;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_bus_req", 32'(bus.o_bus_req), 32'h0);
    checkOutput("rst_bus_addr", 32'(bus.o_bus_addr), 32'h0);
    checkOutput("rst_f_data", bus.o_f_data, 32'h0);
    checkOutput("rst_f_valid", 32'(bus.o_f_data_valid), 32'h0);
    checkOutput("rst_d_ack", 32'(bus.o_d_ack), 32'h0);
    checkOutput("rst_bus_err", 32'(bus.o_bus_err), 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);

    $display("[TB] tie 1: fetch 0x0100 and data read 0x0041 together, data wins");
    n = cyc;
    push_beat(n + 1, 18'h20041, 1'b0, 16'h0, 1);
    push_d(n + 2, 16'h1234);
    push_beat(n + 3, 18'h00200, 1'b0, 16'h0, 1);
    push_beat(n + 5, 18'h00201, 1'b0, 16'h0, 1);
    push_f(n + 6, 32'h5555AAAA);
    applyStimulus(1'b1, 16'h0100, 1'b1, 1'b0, 16'h0041, 16'h0);
    wait_done(1'b1, 1'b1, 30);
    idle(2);

    $display("[TB] data write 0x0040 <- 0xBEEF");
    n = cyc;
    push_beat(n + 1, 18'h20040, 1'b1, 16'hBEEF, 1);
    push_d(n + 2, 16'h0000);
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b1, 16'h0040, 16'hBEEF);
    wait_done(1'b0, 1'b1, 20);
    idle(2);

    $display("[TB] tie 2: fetch 0x0013 and data read 0x0041 together");
    n = cyc;
`ifdef ARB_ROUND_ROBIN_EN
    push_beat(n + 1, 18'h00026, 1'b0, 16'h0, 1);
    push_beat(n + 3, 18'h00027, 1'b0, 16'h0, 1);
    push_f(n + 4, 32'h44443333);
    push_beat(n + 5, 18'h20041, 1'b0, 16'h0, 1);
    push_d(n + 6, 16'h1234);
`else
    push_beat(n + 1, 18'h20041, 1'b0, 16'h0, 1);
    push_d(n + 2, 16'h1234);
    push_beat(n + 3, 18'h00026, 1'b0, 16'h0, 1);
    push_beat(n + 5, 18'h00027, 1'b0, 16'h0, 1);
    push_f(n + 6, 32'h44443333);
`endif
    applyStimulus(1'b1, 16'h0013, 1'b1, 1'b0, 16'h0041, 16'h0);
    wait_done(1'b1, 1'b1, 30);
    idle(2);

    $display("[TB] fetch 0x0012 alone");
    n = cyc;
    push_beat(n + 1, 18'h00024, 1'b0, 16'h0, 1);
    push_beat(n + 3, 18'h00025, 1'b0, 16'h0, 1);
    push_f(n + 4, 32'h22221111);
    applyStimulus(1'b1, 16'h0012, 1'b0, 1'b0, 16'h0, 16'h0);
    wait_done(1'b1, 1'b0, 20);
    idle(2);

    $display("[TB] data read 0x0040 returns the written word");
    n = cyc;
    push_beat(n + 1, 18'h20040, 1'b0, 16'h0, 1);
    push_d(n + 2, 16'hBEEF);
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 16'h0040, 16'h0);
    wait_done(1'b0, 1'b1, 20);
    idle(2);

    $display("[TB] watchdog: data read 0x0050 with memory silent");
    mem_mute = 1'b1;
    n = cyc;
    push_beat(n + 1, 18'h20050, 1'b0, 16'h0, 4);
    err_q.push_back(n + 5);
    push_d(n + 5, 16'hFFFF);
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 16'h0050, 16'h0);
    wait_done(1'b0, 1'b1, 20);
    mem_mute = 1'b0;
    idle(2);

    $display("[TB] fetch dropped during the high beat, pending data read served next");
    n = cyc;
    push_beat(n + 1, 18'h00024, 1'b0, 16'h0, 1);
    push_beat(n + 3, 18'h00025, 1'b0, 16'h0, 1);
    push_beat(n + 5, 18'h20040, 1'b0, 16'h0, 1);
    push_d(n + 6, 16'hBEEF);
    applyStimulus(1'b1, 16'h0012, 1'b0, 1'b0, 16'h0, 16'h0);
    idle(1);
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 16'h0040, 16'h0);
    idle(1);
    bus.i_f_req_active = 1'b0;
    wait_done(1'b0, 1'b1, 20);
    idle(2);

    $display("[TB] reset asserted during a data beat");
    mem_mute = 1'b1;
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 16'h0041, 16'h0);
    idle(1);
    checkOutput("d_acc_bus_req", 32'(bus.o_bus_req), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_bus_req", 32'(bus.o_bus_req), 32'h0);
    checkOutput("rst_mid_bus_addr", 32'(bus.o_bus_addr), 32'h0);
    bus.i_d_req = 1'b0;
    idle(2);
    rst_n    = 1'b1;
    mem_mute = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_d_ack", 32'(bus.o_d_ack), 32'h0);
    checkOutput("post_rst_d_rdata", 32'(bus.o_d_rdata), 32'h0);
    idle(2);

    $display("[TB] data read 0x0041 after reset release");
    n = cyc;
    push_beat(n + 1, 18'h20041, 1'b0, 16'h0, 1);
    push_d(n + 2, 16'h1234);
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 16'h0041, 16'h0);
    wait_done(1'b0, 1'b1, 20);

    idle(5);
    checkOutput("beats_outstanding", 32'(beat_q.size()), 32'h0);
    checkOutput("fetch_outstanding", 32'(f_q.size()), 32'h0);
    checkOutput("data_outstanding", 32'(d_q.size()), 32'h0);
    checkOutput("err_outstanding", 32'(err_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
